// File: rtl/hpdmc_datapath.sv
// hpdmc_datapath: DDR data path for the HPDMC controller.
// Buffers write data in a FIFO and drives registered rise/fall beats,
// per-byte masks and DQ/DQS output enables toward ODDR primitives.
// Captures IDDR read beats after a programmable latency into a read FIFO
// with a valid/ready interface.
// Optional sticky status flags are built when HPDMC_DATAPATH_STATUS_EN is
// defined; otherwise wr_underrun/rd_overflow/cmd_err are tied to 0.
module hpdmc_datapath #(
   parameter int DQ_WIDTH    = 32,
   parameter int BURST_BEATS = 4,
   parameter int DEPTH       = 8,
   parameter int RD_LATENCY  = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        op_write,
   input  logic                        op_read,
   input  logic                        w_valid,
   output logic                        w_ready,
   input  logic [2*DQ_WIDTH-1:0]       w_dat,
   input  logic [2*(DQ_WIDTH/8)-1:0]   w_mask,
   output logic                        r_valid,
   input  logic                        r_ready,
   output logic [2*DQ_WIDTH-1:0]       r_dat,
   output logic [DQ_WIDTH-1:0]         phy_dq_rise,
   output logic [DQ_WIDTH-1:0]         phy_dq_fall,
   output logic [DQ_WIDTH/8-1:0]       phy_dqm_rise,
   output logic [DQ_WIDTH/8-1:0]       phy_dqm_fall,
   output logic                        phy_dq_oe,
   output logic                        phy_dqs_oe,
   input  logic [DQ_WIDTH-1:0]         phy_dq_in_rise,
   input  logic [DQ_WIDTH-1:0]         phy_dq_in_fall,
   output logic                        busy,
   output logic                        wr_underrun,
   output logic                        rd_overflow,
   output logic                        cmd_err,
   input  logic                        err_clr
);

   localparam int NB = DQ_WIDTH / 8;
   localparam int AW = $clog2(DEPTH);
   localparam int BW = $clog2(BURST_BEATS + 1);
   localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
   localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_BEATS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRE,
      ST_DATA,
      ST_POST
   } wr_state_t;

   wr_state_t state, state_nxt;
   logic [BW-1:0] beat_cnt, beat_cnt_nxt;

   // ------------------------------------------------------------------
   // Write FIFO
   // ------------------------------------------------------------------
   logic [2*DQ_WIDTH-1:0] wf_dat_mem [DEPTH];
   logic [2*NB-1:0]       wf_msk_mem [DEPTH];
   logic [AW-1:0]         wf_wr_ptr, wf_rd_ptr;
   logic [AW:0]           wf_count;
   logic                  wf_push, wf_pop_p0, wf_empty;

   assign w_ready   = (wf_count != DEPTH_CNT);
   assign wf_empty  = (wf_count == '0);
   assign wf_push   = w_valid & w_ready;
   // One word leaves the FIFO per DATA cycle; an empty FIFO leaves the beat masked.
   assign wf_pop_p0 = (state == ST_DATA) & ~wf_empty;

   // Write FIFO storage: data only, no reset needed.
   always_ff @(posedge clk) begin
      if (wf_push) begin
         wf_dat_mem[wf_wr_ptr] <= w_dat;
         wf_msk_mem[wf_wr_ptr] <= w_mask;
      end
   end

   // Write FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wf_wr_ptr <= '0;
         wf_rd_ptr <= '0;
         wf_count  <= '0;
      end else begin
         if (wf_push)
            wf_wr_ptr <= wf_wr_ptr + 1'b1;
         if (wf_pop_p0)
            wf_rd_ptr <= wf_rd_ptr + 1'b1;
         case ({wf_push, wf_pop_p0})
            2'b10:   wf_count <= wf_count + 1'b1;
            2'b01:   wf_count <= wf_count - 1'b1;
            default: wf_count <= wf_count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Write burst FSM
   // ------------------------------------------------------------------
   logic last_beat;
   assign last_beat = (state == ST_DATA) && (beat_cnt == '0);

   // FSM state and beat counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         beat_cnt <= beat_cnt_nxt;
      end
   end

   // Next-state logic; op_write in the last DATA cycle chains a burst seamlessly.
   always_comb begin
      state_nxt    = state;
      beat_cnt_nxt = beat_cnt;
      case (state)
         ST_IDLE: begin
            if (op_write)
               state_nxt = ST_PRE;
         end
         ST_PRE: begin
            state_nxt    = ST_DATA;
            beat_cnt_nxt = BEAT_LAST;
         end
         ST_DATA: begin
            if (beat_cnt == '0) begin
               if (op_write)
                  beat_cnt_nxt = BEAT_LAST;
               else
                  state_nxt = ST_POST;
            end else begin
               beat_cnt_nxt = beat_cnt - 1'b1;
            end
         end
         ST_POST: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // ---- stage p0 -> p1: registered PHY write outputs ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phy_dq_rise  <= '0;
         phy_dq_fall  <= '0;
         phy_dqm_rise <= '1;
         phy_dqm_fall <= '1;
         phy_dq_oe    <= 1'b0;
         phy_dqs_oe   <= 1'b0;
      end else begin
         phy_dqs_oe <= (state != ST_IDLE);
         phy_dq_oe  <= (state == ST_DATA);
         if (wf_pop_p0) begin
            phy_dq_rise  <= wf_dat_mem[wf_rd_ptr][DQ_WIDTH-1:0];
            phy_dq_fall  <= wf_dat_mem[wf_rd_ptr][2*DQ_WIDTH-1:DQ_WIDTH];
            phy_dqm_rise <= wf_msk_mem[wf_rd_ptr][NB-1:0];
            phy_dqm_fall <= wf_msk_mem[wf_rd_ptr][2*NB-1:NB];
         end else begin
            phy_dq_rise  <= '0;
            phy_dq_fall  <= '0;
            phy_dqm_rise <= '1;
            phy_dqm_fall <= '1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Read launch pipeline and capture window
   // ------------------------------------------------------------------
   logic [RD_LATENCY-1:0] rd_vld_p;
   logic                  rd_go, rd_tok, rd_cap_p0;
   logic [BW-1:0]         win_cnt;

   // A read colliding with a write in the same cycle is dropped.
   assign rd_go     = op_read & ~op_write;
   assign rd_tok    = rd_vld_p[RD_LATENCY-1];
   // The exiting token itself is the first capture cycle of its window.
   assign rd_cap_p0 = rd_tok | (win_cnt != '0);

   // ---- launch -> capture: RD_LATENCY-deep token shift register ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_vld_p <= '0;
      end else begin
         rd_vld_p[0] <= rd_go;
         for (int i = 1; i < RD_LATENCY; i++)
            rd_vld_p[i] <= rd_vld_p[i-1];
      end
   end

   // Window counter; a token in the final window cycle reloads without a gap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         win_cnt <= '0;
      else if (rd_tok)
         win_cnt <= BEAT_LAST;
      else if (win_cnt != '0)
         win_cnt <= win_cnt - 1'b1;
   end

   // ------------------------------------------------------------------
   // Read FIFO
   // ------------------------------------------------------------------
   logic [2*DQ_WIDTH-1:0] rf_mem [DEPTH];
   logic [AW-1:0]         rf_wr_ptr, rf_rd_ptr;
   logic [AW:0]           rf_count;
   logic                  rf_push, rf_pop, rf_full;

   assign r_valid = (rf_count != '0);
   assign r_dat   = rf_mem[rf_rd_ptr];
   assign rf_full = (rf_count == DEPTH_CNT);
   assign rf_pop  = r_valid & r_ready;
   // A pop in the same cycle frees the slot, so only a truly full FIFO drops.
   assign rf_push = rd_cap_p0 & (~rf_full | rf_pop);

   // Read FIFO storage: data only, no reset needed.
   always_ff @(posedge clk) begin
      if (rf_push)
         rf_mem[rf_wr_ptr] <= {phy_dq_in_fall, phy_dq_in_rise};
   end

   // Read FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_wr_ptr <= '0;
         rf_rd_ptr <= '0;
         rf_count  <= '0;
      end else begin
         if (rf_push)
            rf_wr_ptr <= rf_wr_ptr + 1'b1;
         if (rf_pop)
            rf_rd_ptr <= rf_rd_ptr + 1'b1;
         case ({rf_push, rf_pop})
            2'b10:   rf_count <= rf_count + 1'b1;
            2'b01:   rf_count <= rf_count - 1'b1;
            default: rf_count <= rf_count;
         endcase
      end
   end

   assign busy = (state != ST_IDLE) | (|rd_vld_p) | (win_cnt != '0);

   // ------------------------------------------------------------------
   // Sticky status flags
   // ------------------------------------------------------------------
`ifdef HPDMC_DATAPATH_STATUS_EN
   logic underrun_evt, overflow_evt, cmd_err_evt;

   assign underrun_evt = (state == ST_DATA) & wf_empty;
   assign overflow_evt = rd_cap_p0 & rf_full & ~rf_pop;
   // Write+read together, or a write outside IDLE / last DATA cycle.
   assign cmd_err_evt  = (op_write & op_read) |
                         (op_write & ~((state == ST_IDLE) | last_beat));

   // Sticky flags; a set event beats a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_underrun <= 1'b0;
         rd_overflow <= 1'b0;
         cmd_err     <= 1'b0;
      end else begin
         if (underrun_evt)
            wr_underrun <= 1'b1;
         else if (err_clr)
            wr_underrun <= 1'b0;
         if (overflow_evt)
            rd_overflow <= 1'b1;
         else if (err_clr)
            rd_overflow <= 1'b0;
         if (cmd_err_evt)
            cmd_err <= 1'b1;
         else if (err_clr)
            cmd_err <= 1'b0;
      end
   end
`else
   logic unused_status;
   assign unused_status = err_clr | last_beat;
   assign wr_underrun   = 1'b0;
   assign rd_overflow   = 1'b0;
   assign cmd_err       = 1'b0;
`endif

endmodule

// File: tb/tb_hpdmc_datapath.sv
// Scoreboard bench for hpdmc_datapath: stimulus pushes expected PHY write
// beats and read words into queues; monitors pop and compare on negedges.
module tb_hpdmc_datapath;
   localparam int DQ = 32;
   localparam int NB = DQ / 8;
   localparam int B  = 4;
   localparam int D  = 8;
   localparam int L  = 2;
`ifdef HPDMC_DATAPATH_STATUS_EN
   localparam bit ST = 1'b1;
`else
   localparam bit ST = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              op_write = 1'b0, op_read = 1'b0;
   logic              w_valid = 1'b0, w_ready;
   logic [2*DQ-1:0]   w_dat = '0;
   logic [2*NB-1:0]   w_mask = '0;
   logic              r_valid, r_ready = 1'b1;
   logic [2*DQ-1:0]   r_dat;
   logic [DQ-1:0]     phy_dq_rise, phy_dq_fall;
   logic [NB-1:0]     phy_dqm_rise, phy_dqm_fall;
   logic              phy_dq_oe, phy_dqs_oe;
   logic [DQ-1:0]     phy_dq_in_rise = '0, phy_dq_in_fall = '0;
   logic              busy, wr_underrun, rd_overflow, cmd_err;
   logic              err_clr = 1'b0;

   int checks = 0;
   int errors = 0;
   logic [2*NB+2*DQ-1:0] wq[$];
   logic [2*DQ-1:0]      rq[$];

   hpdmc_datapath #(.DQ_WIDTH(DQ), .BURST_BEATS(B), .DEPTH(D), .RD_LATENCY(L)) dut (
      .clk(clk), .rst(rst), .op_write(op_write), .op_read(op_read),
      .w_valid(w_valid), .w_ready(w_ready), .w_dat(w_dat), .w_mask(w_mask),
      .r_valid(r_valid), .r_ready(r_ready), .r_dat(r_dat),
      .phy_dq_rise(phy_dq_rise), .phy_dq_fall(phy_dq_fall),
      .phy_dqm_rise(phy_dqm_rise), .phy_dqm_fall(phy_dqm_fall),
      .phy_dq_oe(phy_dq_oe), .phy_dqs_oe(phy_dqs_oe),
      .phy_dq_in_rise(phy_dq_in_rise), .phy_dq_in_fall(phy_dq_in_fall),
      .busy(busy), .wr_underrun(wr_underrun), .rd_overflow(rd_overflow),
      .cmd_err(cmd_err), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [2*DQ-1:0] wword(input int i);
      return {32'hF00D_0000 | 32'(i), 32'hC0DE_0000 | 32'(i)};
   endfunction

   function automatic logic [2*DQ-1:0] rpat(input int tag, input int k);
      logic [DQ-1:0] rise;
      rise = {8'h5A, 8'(tag), 16'(k)};
      return {~rise, rise};
   endfunction

   // Write-side monitor: every DQ-enabled cycle carries one expected beat.
   always @(negedge clk) begin
      if (!rst && phy_dq_oe) begin
         if (wq.size() == 0) begin
            checks++; errors++;
            $display("FAIL wr_beat: got unexpected beat %0h expected none", {phy_dq_fall, phy_dq_rise});
         end else begin
            chk("wr_beat", {phy_dqm_fall, phy_dqm_rise, phy_dq_fall, phy_dq_rise}, wq.pop_front());
         end
      end
   end

   // Read-side monitor: every accepted pop must match the next expected word.
   always @(negedge clk) begin
      if (!rst && r_valid && r_ready) begin
         if (rq.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_word: got unexpected word %0h expected none", r_dat);
         end else begin
            chk("rd_word", r_dat, rq.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic push_word(input logic [2*DQ-1:0] d, input logic [2*NB-1:0] m);
      w_dat = d; w_mask = m; w_valid = 1'b1;
      tick();
      w_valid = 1'b0;
      wq.push_back({m, d});
   endtask

   // op_write at edge T (plus optional op_read), second op_write sampled at T+second_k+1.
   task automatic wr_window(input int second_k, input int dq_last, input int dqs_last, input bit with_read);
      op_write = 1'b1; op_read = with_read;
      tick();
      op_read = 1'b0;
      for (int k = 0; k < dqs_last + 3; k++) begin
         op_write = (k == second_k);
         @(negedge clk);
         chk($sformatf("dqs_oe[T+%0d]", k), phy_dqs_oe, (k >= 1 && k <= dqs_last));
         chk($sformatf("dq_oe[T+%0d]", k), phy_dq_oe, (k >= 2 && k <= dq_last));
         if (!(k >= 2 && k <= dq_last))
            chk($sformatf("idle_dqm[T+%0d]", k), {phy_dqm_fall, phy_dqm_rise, phy_dq_rise}, {8'hFF, 32'h0});
         tick();
      end
      op_write = 1'b0;
   endtask

   // nreq op_reads spaced BURST_BEATS apart with a ramping IDDR input.
   task automatic rd_run(input int tag, input int nreq, input int store_max, input bit chk_vld);
      int n;
      n = 0;
      for (int k = L; k < L + nreq * B; k++) begin
         if (n < store_max) rq.push_back(rpat(tag, k));
         n++;
      end
      for (int k = 0; k <= L + nreq * B + 1; k++) begin
         op_read = (k % B == 0) && (k < nreq * B);
         {phy_dq_in_fall, phy_dq_in_rise} = rpat(tag, k);
         @(negedge clk);
         if (chk_vld && k == L)     chk("r_valid_before", r_valid, 1'b0);
         if (chk_vld && k == L + 1) chk("r_valid_after", r_valid, 1'b1);
         tick();
      end
      op_read = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_oe", {phy_dq_oe, phy_dqs_oe}, 2'b00);
      chk("rst_dq", {phy_dq_fall, phy_dq_rise}, 64'h0);
      chk("rst_dqm", {phy_dqm_fall, phy_dqm_rise}, 8'hFF);
      chk("rst_hs", {w_ready, r_valid, busy}, 3'b100);
      chk("rst_flags", {wr_underrun, rd_overflow, cmd_err}, 3'b000);
      tick();
      rst = 1'b0;
      tick();

      // Single write burst.
      for (int i = 1; i <= 4; i++) push_word(wword(i), 8'h00);
      @(negedge clk);
      chk("busy_idle", busy, 1'b0);
      tick();
      wr_window(-1, B + 1, B + 2, 1'b0);

      // Back-to-back bursts filling the FIFO to DEPTH.
      for (int i = 5; i <= 12; i++) push_word(wword(i), 8'(i));
      chk("w_ready_full", w_ready, 1'b0);
      wr_window(4, 9, 10, 1'b0);
      chk("w_ready_empty", w_ready, 1'b1);

      // Underrun: only two words for a four-beat burst.
      push_word(wword(21), 8'h3C);
      push_word(wword(22), 8'h00);
      wq.push_back({8'hFF, 64'h0});
      wq.push_back({8'hFF, 64'h0});
      wr_window(-1, B + 1, B + 2, 1'b0);
      chk("underrun_flag", wr_underrun, ST);
      chk("no_other_flags", {rd_overflow, cmd_err}, 2'b00);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("underrun_clr", wr_underrun, 1'b0);

      // Single read with immediate drain.
      r_ready = 1'b1;
      rd_run(1, 1, 100, 1'b1);
      repeat (2) tick();
      chk("rd_drained", r_valid, 1'b0);

      // Overflow: three windows into an 8-entry FIFO with no pops.
      r_ready = 1'b0;
      rd_run(2, 3, D, 1'b0);
      chk("ovf_flag", rd_overflow, ST);
      chk("ovf_valid", r_valid, 1'b1);
      r_ready = 1'b1;
      for (int i = 0; i < 20 && r_valid; i++) tick();
      chk("ovf_drained", r_valid, 1'b0);
      chk("rq_empty", rq.size(), 0);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("ovf_clr", rd_overflow, 1'b0);

      // Conflict: write+read together, then a write during PRE is ignored.
      for (int i = 31; i <= 34; i++) push_word(wword(i), 8'h00);
      wr_window(0, B + 1, B + 2, 1'b1);
      chk("cmd_err_flag", cmd_err, ST);
      chk("conflict_no_read", r_valid, 1'b0);

      // Asynchronous reset in the middle of DATA.
      for (int i = 41; i <= 44; i++) push_word(wword(i), 8'h00);
      op_write = 1'b1; tick(); op_write = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_oe", {phy_dq_oe, phy_dqs_oe}, 2'b00);
      chk("mid_rst_dqm", {phy_dqm_fall, phy_dqm_rise}, 8'hFF);
      chk("mid_rst_ready", {w_ready, busy}, 2'b10);
      chk("mid_rst_flags", {wr_underrun, rd_overflow, cmd_err}, 3'b000);
      wq.delete();
      tick();
      rst = 1'b0;
      repeat (2) tick();
      chk("post_rst_oe", {phy_dq_oe, phy_dqs_oe}, 2'b00);
      chk("wq_empty", wq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
